// File: rtl/dcache_loader_pkg.sv
// Shared types and constants for the D-cache backdoor loader.
package dcache_loader_pkg;

    localparam int LD_DPW        = 32;
    localparam int LD_MAX_WORDS  = 256;

    localparam int LD_ADDR_BYTES = 4;
    localparam int LD_CNT_BYTES  = 2;
    localparam int LD_WORD_BYTES = LD_DPW / 8;

    typedef enum logic [2:0] {
        ST_ADDR,
        ST_CNT,
        ST_DATA,
        ST_WRITE,
        ST_DONE
    } loader_state_t;

endpackage

// File: rtl/dcache_loader_byte_packer.sv
// Little-endian byte collector shared by the address, count and payload fields.
module byte_packer #(
    parameter int W  = 32,
    parameter int IW = 2
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          i_clear,
    input  logic          i_shift,
    input  logic [7:0]    i_byte,
    input  logic [IW-1:0] i_last_idx,
    output logic          o_full,
    output logic [W-1:0]  o_word
);

    logic [W-1:0]  r_data;
    logic [IW-1:0] r_idx;
    logic [W-1:0]  w_merged;

    // The merged view includes the byte being shifted this cycle, so the
    // caller can capture a complete field on the same edge as its last byte.
    always_comb begin
        w_merged = r_data;
        w_merged[r_idx*8 +: 8] = i_byte;
    end

    assign o_full = (r_idx == i_last_idx);
    assign o_word = w_merged;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_clear) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_shift) begin
            r_data <= w_merged;
            if (o_full) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_loader.sv
// Parses addr/count/payload frames from a byte stream and issues one D-cache write per word.
module dcache_loader
    import dcache_loader_pkg::*;
#(
    parameter int DPW       = LD_DPW,
    parameter int MAX_WORDS = LD_MAX_WORDS
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           s_valid,
    input  logic [7:0]     s_data,
    output logic           s_ready,
    output logic           data_en,
    output logic [DPW-1:0] input_data,
    output logic [DPW-1:0] input_addr,
    output logic           core_hold,
    output logic           load_done,
    output logic           load_err,
    output logic [15:0]    words_written,
    output logic [DPW-1:0] checksum,
    output loader_state_t  o_dbg_state
);

    // Stream handshake: a byte moves only on a cycle where s_valid && s_ready;
    // s_ready depends on state alone, never on s_valid.
    localparam int IW = $clog2(DPW / 8);
    localparam logic [IW-1:0] IDX_ADDR = IW'(LD_ADDR_BYTES - 1);
    localparam logic [IW-1:0] IDX_CNT  = IW'(LD_CNT_BYTES - 1);
    localparam logic [IW-1:0] IDX_WORD = IW'(DPW / 8 - 1);
    localparam logic [15:0]   MAX_N    = 16'(MAX_WORDS);

    loader_state_t  r_state;
    loader_state_t  w_next;

    logic [DPW-1:0] r_addr;
    logic [15:0]    r_remaining;
    logic [15:0]    r_words;
    logic [DPW-1:0] r_checksum;
    logic [DPW-1:0] r_in_data;
    logic [DPW-1:0] r_in_addr;
    logic           r_hold;
    logic           r_err;

    logic           w_s_ready;
    logic           w_data_en;
    logic           w_load_done;
    logic [IW-1:0]  w_last_idx;
    logic           w_accept;
    logic           w_field_done;
    logic           w_pk_clear;
    logic [DPW-1:0] w_word;
    logic [15:0]    w_cnt;

    assign w_accept   = s_valid && w_s_ready;
    assign w_pk_clear = (r_state == ST_DONE);
    assign w_cnt      = w_word[15:0];

    byte_packer #(
        .W  (DPW),
        .IW (IW)
    ) u_packer (
        .clk        (clk),
        .arst_n     (arst_n),
        .i_clear    (w_pk_clear),
        .i_shift    (w_accept),
        .i_byte     (s_data),
        .i_last_idx (w_last_idx),
        .o_full     (w_field_done),
        .o_word     (w_word)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= ST_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_ADDR: begin
                if (w_accept && w_field_done) w_next = ST_CNT;
            end
            ST_CNT: begin
                if (w_accept && w_field_done) begin
                    if (w_cnt == 16'd0) begin
                        w_next = ST_DONE;
                    end else if (w_cnt > MAX_N) begin
                        w_next = ST_ADDR;
                    end else begin
                        w_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_accept && w_field_done) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                w_next = (r_remaining == 16'd1) ? ST_DONE : ST_DATA;
            end
            ST_DONE: begin
                w_next = ST_ADDR;
            end
            default: begin
                w_next = ST_ADDR;
            end
        endcase
    end

    always_comb begin
        w_s_ready   = 1'b0;
        w_data_en   = 1'b0;
        w_load_done = 1'b0;
        w_last_idx  = IDX_WORD;
        unique case (r_state)
            ST_ADDR: begin
                w_s_ready  = 1'b1;
                w_last_idx = IDX_ADDR;
            end
            ST_CNT: begin
                w_s_ready  = 1'b1;
                w_last_idx = IDX_CNT;
            end
            ST_DATA:  w_s_ready   = 1'b1;
            ST_WRITE: w_data_en   = 1'b1;
            ST_DONE:  w_load_done = 1'b1;
            default:  w_s_ready   = 1'b0;
        endcase
    end

    // Write data/address are captured with the last payload byte so they are
    // stable for the whole write cycle and hold afterwards.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_words     <= '0;
            r_checksum  <= '0;
            r_in_data   <= '0;
            r_in_addr   <= '0;
            r_hold      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            unique case (r_state)
                ST_ADDR: begin
                    if (w_accept && !r_hold) begin
                        r_hold     <= 1'b1;
                        r_words    <= '0;
                        r_checksum <= '0;
                    end
                    if (w_accept && w_field_done) begin
                        r_addr <= {w_word[DPW-1:2], 2'b00};
                    end
                end
                ST_CNT: begin
                    if (w_accept && w_field_done) begin
                        r_remaining <= w_cnt;
                        if (w_cnt > MAX_N) begin
                            r_err  <= 1'b1;
                            r_hold <= 1'b0;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_accept && w_field_done) begin
                        r_in_data <= w_word;
                        r_in_addr <= r_addr;
                    end
                end
                ST_WRITE: begin
                    r_words     <= r_words + 16'd1;
                    r_checksum  <= r_checksum ^ r_in_data;
                    r_addr      <= r_addr + DPW'(4);
                    r_remaining <= r_remaining - 16'd1;
                end
                ST_DONE: begin
                    r_hold <= 1'b0;
                end
                default: begin
                    r_hold <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready       = w_s_ready;
    assign data_en       = w_data_en;
    assign load_done     = w_load_done;
    assign input_data    = r_in_data;
    assign input_addr    = r_in_addr;
    assign core_hold     = r_hold;
    assign load_err      = r_err;
    assign words_written = r_words;
    assign checksum      = r_checksum;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_dcache_loader.sv
// Randomized frame bench for dcache_loader with a queue-based reference model.
module tb_dcache_loader;
    import dcache_loader_pkg::*;

    localparam int DPW       = 32;
    localparam int MAX_WORDS = 256;

    logic           clk = 1'b0;
    logic           arst_n = 1'b0;
    logic           s_valid = 1'b0;
    logic [7:0]     s_data = 8'h00;
    logic           s_ready;
    logic           data_en;
    logic [DPW-1:0] input_data;
    logic [DPW-1:0] input_addr;
    logic           core_hold;
    logic           load_done;
    logic           load_err;
    logic [15:0]    words_written;
    logic [DPW-1:0] checksum;
    loader_state_t  dbg_state;

    dcache_loader #(
        .DPW       (DPW),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .data_en       (data_en),
        .input_data    (input_data),
        .input_addr    (input_addr),
        .core_hold     (core_hold),
        .load_done     (load_done),
        .load_err      (load_err),
        .words_written (words_written),
        .checksum      (checksum),
        .o_dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          gap_max = 2;
    logic [63:0] exp_q[$];
    logic [47:0] done_q[$];
    logic [31:0] frame_words[$];
    logic        exp_err   = 1'b0;
    logic [15:0] last_words = 16'd0;
    logic [31:0] last_cs    = 32'd0;
    logic [63:0] mon_e;
    logic [47:0] mon_d;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (arst_n) begin
            if (data_en) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                             input_addr, input_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", 64'(input_addr), 64'(mon_e[63:32]));
                    check("write_data", 64'(input_data), 64'(mon_e[31:0]));
                    check("hold_during_write", 64'(core_hold), 64'd1);
                end
            end
            if (load_done) begin
                if (done_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_done: got load_done=1 expected 0");
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_words", 64'(words_written), 64'(mon_d[47:32]));
                    check("done_checksum", 64'(checksum), 64'(mon_d[31:0]));
                end
            end
        end
    end

    task automatic apply_reset();
        #2;
        arst_n  = 1'b0;
        s_valid = 1'b0;
        #3;
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_data_en", 64'(data_en), 64'd0);
        check("rst_input_data", 64'(input_data), 64'd0);
        check("rst_input_addr", 64'(input_addr), 64'd0);
        check("rst_core_hold", 64'(core_hold), 64'd0);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_load_err", 64'(load_err), 64'd0);
        check("rst_words", 64'(words_written), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_ADDR));
        exp_err    = 1'b0;
        last_words = 16'd0;
        last_cs    = 32'd0;
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        bit ok;
        gap = $urandom_range(0, gap_max);
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = b;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got s_ready=0 for 100 cycles expected 1");
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = 8'($urandom);
    endtask

    // Reference model: expected writes follow directly from base, N and payload;
    // abort >= 0 stops after that many payload bytes and resets the DUT.
    task automatic run_frame(input logic [31:0] base, input int n, input int abort);
        logic [31:0] a;
        logic [31:0] cs;
        logic [15:0] cnt;
        cnt = 16'(n);
        if (n > MAX_WORDS) begin
            exp_err    = 1'b1;
            last_words = 16'd0;
            last_cs    = 32'd0;
        end else begin
            a  = base & 32'hFFFF_FFFC;
            cs = 32'd0;
            for (int i = 0; i < n; i++) begin
                if (abort < 0 || 4 * i + 4 <= abort) exp_q.push_back({a, frame_words[i]});
                cs = cs ^ frame_words[i];
                a  = a + 32'd4;
            end
            if (abort < 0) begin
                done_q.push_back({cnt, cs});
                last_words = cnt;
                last_cs    = cs;
            end
        end
        for (int i = 0; i < 4; i++) send_byte(base[8*i +: 8]);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 4; j++) begin
                    if (abort >= 0 && 4 * i + j >= abort) begin
                        apply_reset();
                        return;
                    end
                    send_byte(frame_words[i][8*j +: 8]);
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (exp_q.size() == 0 && done_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_drain: got %0d writes %0d dones pending expected 0", name,
                     exp_q.size(), done_q.size());
        end
        repeat (3) @(negedge clk);
        check({name, "_hold"}, 64'(core_hold), 64'd0);
        check({name, "_ready"}, 64'(s_ready), 64'd1);
        check({name, "_err"}, 64'(load_err), 64'(exp_err));
        check({name, "_words"}, 64'(words_written), 64'(last_words));
        check({name, "_checksum"}, 64'(checksum), 64'(last_cs));
        @(posedge clk);
        #1;
    endtask

    task automatic random_words(input int n);
        frame_words.delete();
        for (int i = 0; i < n; i++) frame_words.push_back($urandom);
    endtask

    task automatic ref_words();
        frame_words.delete();
        frame_words.push_back(32'h4433_2211);
        frame_words.push_back(32'hDDCC_BBAA);
    endtask

    initial begin
        @(posedge clk);
        #1;
        apply_reset();

        ref_words();
        run_frame(32'h0000_0100, 2, -1);
        wait_idle("basic");

        frame_words.delete();
        run_frame(32'h0000_0200, 0, -1);
        wait_idle("zero_count");

        random_words(4);
        run_frame(32'h0000_0300, 257, -1);
        wait_idle("too_many");
        ref_words();
        run_frame(32'h0000_0100, 2, -1);
        wait_idle("after_err");

        random_words(2);
        run_frame(32'hFFFF_FFFC, 2, -1);
        random_words(3);
        run_frame(32'h0000_0103, 3, -1);
        wait_idle("wrap_align");

        gap_max = 0;
        random_words(MAX_WORDS);
        run_frame($urandom, MAX_WORDS, -1);
        wait_idle("max_count");

        gap_max = 3;
        ref_words();
        run_frame(32'h0000_0100, 2, 2);
        wait_idle("abort");
        ref_words();
        run_frame(32'h0000_0100, 2, -1);
        wait_idle("post_abort");
        check("post_abort_words_abs", 64'(words_written), 64'd2);
        check("post_abort_cs_abs", 64'(checksum), 64'(32'h4433_2211 ^ 32'hDDCC_BBAA));

        for (int f = 0; f < 6; f++) begin
            gap_max = $urandom_range(0, 2);
            random_words($urandom_range(1, 6));
            run_frame($urandom, frame_words.size(), -1);
        end
        wait_idle("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
